// File: rtl/vmem_pkg.sv
// Shared constants, FSM state type and address/clip helpers for the video
// memory fill controller.
package vmem_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int HW       = 10;
  localparam int VW       = 9;
  localparam int CW       = 24;
  localparam int AW       = HW + VW;

  // One bit wider than the horizontal field so extents and ends never wrap.
  typedef logic [HW:0] ext_t;

  localparam ext_t H_LIM = ext_t'(H_ACTIVE);
  localparam ext_t V_LIM = ext_t'(V_ACTIVE);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  function automatic logic [AW-1:0] pack_addr(input logic [HW-1:0] h,
                                               input logic [VW-1:0] v);
    return {h, v};
  endfunction

  function automatic ext_t clip_extent(input ext_t origin, input ext_t size,
                                       input ext_t limit);
    ext_t room;
    room = limit - origin;
    if (origin >= limit) return '0;
    return (size < room) ? size : room;
  endfunction

endpackage

// File: rtl/vmem_fill_ctrl_if.sv
// Display, command and memory-side signals of the fill controller.
interface vmem_fill_ctrl_if import vmem_pkg::*; ;

  logic          disp_valid;
  logic [HW-1:0] disp_h_addr;
  logic [VW-1:0] disp_v_addr;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [HW-1:0] cmd_x0;
  logic [VW-1:0] cmd_y0;
  logic [HW-1:0] cmd_w;
  logic [VW-1:0] cmd_h;
  logic [CW-1:0] cmd_color;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [CW-1:0] mem_wdata;
  logic          busy;
  logic          done;
  logic [15:0]   stall_cnt;

  modport slave (
    input  disp_valid, disp_h_addr, disp_v_addr,
    input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
    output cmd_ready, mem_addr, mem_we, mem_wdata, busy, done, stall_cnt
  );

  modport master (
    output disp_valid, disp_h_addr, disp_v_addr,
    output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, mem_addr, mem_we, mem_wdata, busy, done, stall_cnt
  );

endinterface

// File: rtl/rect_walker.sv
// Row-major x/y walker over a clipped rectangle; advances one pixel per
// enabled cycle and flags the final pixel.
module rect_walker import vmem_pkg::*; (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          adv,
  input  logic [HW-1:0] x0,
  input  logic [VW-1:0] y0,
  input  ext_t          ew,
  input  ext_t          eh,
  output logic [HW-1:0] cur_x,
  output logic [VW-1:0] cur_y,
  output logic          last
);

  logic [HW-1:0] x_org;
  ext_t          x_end;
  ext_t          y_end;
  logic          row_end;

  assign row_end = (ext_t'(cur_x) == x_end);
  assign last    = row_end && (ext_t'(cur_y) == y_end);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x <= '0;
      cur_y <= '0;
      x_org <= '0;
      x_end <= '0;
      y_end <= '0;
    end else if (load) begin
      cur_x <= x0;
      cur_y <= y0;
      x_org <= x0;
      x_end <= ext_t'(x0) + ew - ext_t'(1);
      y_end <= ext_t'(y0) + eh - ext_t'(1);
    end else if (adv) begin
      if (row_end) begin
        cur_x <= x_org;
        cur_y <= cur_y + VW'(1);
      end else begin
        cur_x <= cur_x + HW'(1);
      end
    end
  end

endmodule

// File: rtl/vmem_fill_ctrl.sv
// Arbitrates the single-port frame memory between display reads (absolute
// priority, zero added latency) and rectangle-fill writes in blanking cycles.
module vmem_fill_ctrl import vmem_pkg::*; (
  input  logic              clk,
  input  logic              resetn,
  vmem_fill_ctrl_if.slave   bus
);

  state_t        state;
  logic          cmd_ready_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] color_q;
  logic [15:0]   stall_q;

  ext_t          ew;
  ext_t          eh;
  logic          empty;
  logic          accept;
  logic          wr_en;
  logic          last;
  logic [HW-1:0] cur_x;
  logic [VW-1:0] cur_y;
  logic [AW-1:0] mem_addr;

  assign ew     = clip_extent(ext_t'(bus.cmd_x0), ext_t'(bus.cmd_w), H_LIM);
  assign eh     = clip_extent(ext_t'(bus.cmd_y0), ext_t'(bus.cmd_h), V_LIM);
  assign empty  = (ew == '0) || (eh == '0);
  assign accept = cmd_ready_q && bus.cmd_valid;
  assign wr_en  = (state == FILL) && !bus.disp_valid;

  rect_walker u_walker (
    .clk   (clk),
    .rst_n (resetn),
    .load  (accept && !empty),
    .adv   (wr_en),
    .x0    (bus.cmd_x0),
    .y0    (bus.cmd_y0),
    .ew    (ew),
    .eh    (eh),
    .cur_x (cur_x),
    .cur_y (cur_y),
    .last  (last)
  );

  // Display address passes straight through unless a fill write owns the cycle.
  always_comb begin
    // NOTE: assign a default first so no path through the block infers a latch.
    mem_addr = pack_addr(bus.disp_h_addr, bus.disp_v_addr);
    if (wr_en) mem_addr = pack_addr(cur_x, cur_y);
  end

  assign bus.mem_addr  = mem_addr;
  assign bus.mem_we    = wr_en;
  assign bus.mem_wdata = color_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stall_cnt = stall_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      color_q     <= '0;
      stall_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            color_q     <= bus.cmd_color;
            cmd_ready_q <= 1'b0;
            if (empty) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state   <= FILL;
              busy_q  <= 1'b1;
              stall_q <= '0;
            end
          end
        end
        FILL: begin
          if (bus.disp_valid) begin
            if (stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
          end else if (last) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          done_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vmem_fill_ctrl.sv
// Scoreboard bench for vmem_fill_ctrl: stimulus pushes expected writes, a
// negedge monitor pops and compares every memory write.
module tb_vmem_fill_ctrl;
  import vmem_pkg::*;

  typedef struct {
    int            x0;
    int            y0;
    int            w;
    int            h;
    logic [CW-1:0] color;
  } cmd_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  vmem_fill_ctrl_if bus ();

  vmem_fill_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  wr_t           exp_q[$];
  wr_t           mon_e;
  int            n_vec  = 0;
  int            n_fail = 0;
  logic [AW-1:0] disp_addr = {10'd100, 9'd5};

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write the DUT issues must match the head of the queue.
  always @(negedge clk) begin
    if (resetn && bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("write_without_expect", 64'(bus.mem_we), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(bus.mem_addr), 64'(mon_e.addr));
        check("wr_data", 64'(bus.mem_wdata), 64'(mon_e.data));
      end
    end
  end

  // Reference model: enumerate the requested rectangle and keep on-screen pixels.
  task automatic push_rect(input cmd_t c);
    wr_t           e;
    logic [HW-1:0] hx;
    logic [VW-1:0] vy;
    for (int y = c.y0; y < c.y0 + c.h; y++) begin
      for (int x = c.x0; x < c.x0 + c.w; x++) begin
        if (x < 640 && y < 480) begin
          hx = HW'(x);
          vy = VW'(y);
          e.addr = {hx, vy};
          e.data = c.color;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic drive_fields(input cmd_t c);
    bus.cmd_x0    = HW'(c.x0);
    bus.cmd_y0    = VW'(c.y0);
    bus.cmd_w     = HW'(c.w);
    bus.cmd_h     = VW'(c.h);
    bus.cmd_color = c.color;
  endtask

  task automatic send(input cmd_t c);
    @(posedge clk);
    #1;
    drive_fields(c);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    check("cmd_ready_at_offer", 64'(bus.cmd_ready), 64'd1);
  endtask

  // Cycle k=1 is the first cycle after the accept edge.
  task automatic track(input cmd_t next, input bit hold, input int stall_lo,
                       input int stall_hi, input int exp_done,
                       input int exp_stalls, input string tag);
    int done_cyc = 0;
    for (int k = 1; k <= 500 && done_cyc == 0; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        drive_fields(next);
        bus.cmd_valid = hold;
      end
      bus.disp_valid = (k >= stall_lo && k <= stall_hi);
      @(negedge clk);
      if (bus.disp_valid) begin
        check({tag, "_stall_we"}, 64'(bus.mem_we), 64'd0);
        check({tag, "_stall_addr"}, 64'(bus.mem_addr), 64'(disp_addr));
      end
      if (bus.done === 1'b1) done_cyc = k;
    end
    bus.disp_valid = 1'b0;
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
    if (done_cyc != 0) begin
      check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      check({tag, "_ready_at_done"}, 64'(bus.cmd_ready), 64'd0);
      check({tag, "_stall_cnt"}, 64'(bus.stall_cnt), 64'(exp_stalls));
      @(posedge clk);
      #1;
      @(negedge clk);
      check({tag, "_ready_after"}, 64'(bus.cmd_ready), 64'd1);
      check({tag, "_done_after"}, 64'(bus.done), 64'd0);
      check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t basic, clip_a, clip_b, zero, big, after_rst, cmd_a, cmd_b, junk;
    basic     = '{10, 20, 3, 2, 24'hFF0000};
    clip_a    = '{638, 479, 5, 4, 24'h00FF00};
    clip_b    = '{700, 10, 4, 4, 24'h0000FF};
    zero      = '{12, 12, 0, 7, 24'h777777};
    big       = '{0, 0, 10, 10, 24'h111111};
    after_rst = '{5, 7, 2, 2, 24'hABCDEF};
    cmd_a     = '{10, 20, 3, 2, 24'h00FF00};
    cmd_b     = '{30, 40, 2, 1, 24'h0000FF};
    junk      = '{5, 5, 50, 50, 24'h123456};

    bus.disp_valid  = 1'b0;
    bus.disp_h_addr = 10'd100;
    bus.disp_v_addr = 9'd5;
    bus.cmd_valid   = 1'b0;
    drive_fields(junk);

    #22;
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'(disp_addr));
    #1 resetn = 1'b1;

    // Basic fill: 6 writes, done one cycle after the last.
    push_rect(basic);
    send(basic);
    track(junk, 1'b0, 0, -1, 7, 0, "basic");

    // Display owns cycles 2-4: three stalls, same six writes.
    push_rect(basic);
    send(basic);
    track(junk, 1'b0, 2, 4, 10, 3, "disp_prio");

    // Clipped at the bottom-right corner: two writes.
    push_rect(clip_a);
    send(clip_a);
    track(junk, 1'b0, 0, -1, 3, 0, "clip_corner");

    // Origin off-screen: no writes, done right after accept.
    push_rect(clip_b);
    send(clip_b);
    track(junk, 1'b0, 0, -1, 1, 0, "clip_off");

    // Zero width: no writes, one DONE cycle.
    push_rect(zero);
    send(zero);
    track(junk, 1'b0, 0, -1, 1, 0, "zero");

    // Reset during a 100-pixel fill after three writes.
    exp_q.push_back('{{10'd0, 9'd0}, big.color});
    exp_q.push_back('{{10'd1, 9'd0}, big.color});
    exp_q.push_back('{{10'd2, 9'd0}, big.color});
    send(big);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_we", 64'(bus.mem_we), 64'd1);
    check("pre_rst_addr", 64'(bus.mem_addr), 64'({10'd3, 9'd0}));
    #1 resetn = 1'b0;
    #1;
    check("mid_rst_we", 64'(bus.mem_we), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_ready", 64'(bus.cmd_ready), 64'd1);
    check("mid_rst_stall", 64'(bus.stall_cnt), 64'd0);
    check("mid_rst_writes_seen", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 64'(bus.busy), 64'd0);
    check("post_rst_ready", 64'(bus.cmd_ready), 64'd1);
    push_rect(after_rst);
    send(after_rst);
    track(junk, 1'b0, 0, -1, 5, 0, "after_rst");

    // Back-to-back: B offered throughout A's FILL and DONE.
    push_rect(cmd_a);
    send(cmd_a);
    track(cmd_b, 1'b1, 0, -1, 7, 0, "b2b_a");
    push_rect(cmd_b);
    track(junk, 1'b0, 0, -1, 3, 0, "b2b_b");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
